// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word type, request-unit FSM states and watchdog saturation limit
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, DATA, COMMIT, HALTED} reqstate_t;
  localparam logic [7:0] WD_SAT = 8'hff;
endpackage

// File: rtl/request_perf.sv
// request_perf: 32-bit wrapping commit/stall counters (in CLK, nRST, commit, stall; out instr_cnt, stall_cnt)
module request_perf (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        commit,
  input  logic        stall,
  output logic [31:0] instr_cnt,
  output logic [31:0] stall_cnt
);
  logic [31:0] instr_cnt_q, instr_cnt_d, stall_cnt_q, stall_cnt_d;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      instr_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      instr_cnt_q <= instr_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  always_comb begin
    instr_cnt_d = instr_cnt_q + {31'b0, commit};
    stall_cnt_d = stall_cnt_q + {31'b0, stall};
    instr_cnt = instr_cnt_q;
    stall_cnt = stall_cnt_q;
  end
endmodule

// File: rtl/request_unit.sv
// request_unit: fetch/data request sequencer FSM with commit strobes, sticky halt and stall watchdog (bus in: ihit/iload/dhit/dload, cu in: cu_dREN/cu_dWEN/cu_halt; out: imemREN/dmemREN/dmemWEN/instr/dload_q/pc_en/wb_en/halt/stall_err/perf_*; perf counters only with `REQ_PERF_EN)
module request_unit
  import cpu_types_pkg::*;
#(
  parameter int STALL_MAX = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  word_t       iload,
  input  logic        dhit,
  input  word_t       dload,
  input  logic        cu_dREN,
  input  logic        cu_dWEN,
  input  logic        cu_halt,
  output logic        imemREN,
  output logic        dmemREN,
  output logic        dmemWEN,
  output word_t       instr,
  output word_t       dload_q,
  output logic        pc_en,
  output logic        wb_en,
  output logic        halt,
  output logic        stall_err,
  output logic [31:0] perf_instr_cnt,
  output logic [31:0] perf_stall_cnt
);
  localparam logic [7:0] STALL_LIM = 8'(STALL_MAX);
  reqstate_t  state_q, state_d;
  logic       rd_q, rd_d, wr_q, wr_d, stall_err_q, stall_err_d, stall;
  word_t      instr_q, instr_d, dload_d;
  logic [7:0] wd_q, wd_d;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state_q     <= IDLE;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      stall_err_q <= 1'b0;
      instr_q     <= '0;
      dload_q     <= '0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      stall_err_q <= stall_err_d;
      instr_q     <= instr_d;
      dload_q     <= dload_d;
      wd_q        <= wd_d;
    end
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    instr_d = instr_q;
    dload_d = dload_q;
    stall   = (state_q == FETCH && !ihit) || (state_q == DATA && !dhit);
    case (state_q)
      IDLE:   state_d = FETCH;
      FETCH:  if (ihit) begin
                instr_d = iload;
                state_d = DECODE;
              end
      DECODE: if (cu_halt) state_d = HALTED;
              else if (cu_dWEN) begin
                wr_d    = 1'b1;
                state_d = DATA;
              end else if (cu_dREN) begin
                rd_d    = 1'b1;
                state_d = DATA;
              end else state_d = COMMIT;
      DATA:   if (dhit) begin
                dload_d = dload;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                state_d = COMMIT;
              end
      COMMIT: state_d = FETCH;
      default: state_d = HALTED;
    endcase
    // a stall cycle never changes state and every other cycle does (or is HALTED), so clearing on !stall covers "clear on state change"
    wd_d        = stall ? wd_q + {7'b0, wd_q != WD_SAT} : '0;
    stall_err_d = stall_err_q || wd_d == STALL_LIM;
  end
  always_comb begin
    imemREN   = state_q == FETCH;
    dmemREN   = state_q == DATA && rd_q;
    dmemWEN   = state_q == DATA && wr_q;
    pc_en     = state_q == COMMIT;
    wb_en     = state_q == COMMIT;
    halt      = state_q == HALTED;
    instr     = instr_q;
    stall_err = stall_err_q;
  end
`ifdef REQ_PERF_EN
  request_perf u_perf (
    .CLK       (CLK),
    .nRST      (nRST),
    .commit    (pc_en),
    .stall     (stall),
    .instr_cnt (perf_instr_cnt),
    .stall_cnt (perf_stall_cnt)
  );
`else
  assign perf_instr_cnt = '0;
  assign perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_request_unit.sv
// tb_request_unit: directed scoreboard bench for request_unit
module tb_request_unit;
  import cpu_types_pkg::*;
`ifdef REQ_PERF_EN
  localparam logic [31:0] PERF_EXP = 32'd5;
`else
  localparam logic [31:0] PERF_EXP = 32'd0;
`endif
  logic        clk = 1'b0, nrst, ihit, dhit, cu_dren, cu_dwen, cu_halt;
  word_t       iload, dload, instr, dload_q;
  logic        imem_ren, dmem_ren, dmem_wen, pc_en, wb_en, halt, stall_err;
  logic [31:0] perf_instr_cnt, perf_stall_cnt;
  word_t       iq[$], dq[$];
  int          checks = 0, errors = 0;
  request_unit #(.STALL_MAX(16)) dut (
    .CLK            (clk),
    .nRST           (nrst),
    .ihit           (ihit),
    .iload          (iload),
    .dhit           (dhit),
    .dload          (dload),
    .cu_dREN        (cu_dren),
    .cu_dWEN        (cu_dwen),
    .cu_halt        (cu_halt),
    .imemREN        (imem_ren),
    .dmemREN        (dmem_ren),
    .dmemWEN        (dmem_wen),
    .instr          (instr),
    .dload_q        (dload_q),
    .pc_en          (pc_en),
    .wb_en          (wb_en),
    .halt           (halt),
    .stall_err      (stall_err),
    .perf_instr_cnt (perf_instr_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic pop_instr(input string tag);
    if (iq.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed empty instr scoreboard expected entry", tag);
    end else chk(tag, instr, iq.pop_front());
  endtask
  task automatic pop_dload(input string tag);
    if (dq.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed empty dload scoreboard expected entry", tag);
    end else chk(tag, dload_q, dq.pop_front());
  endtask
  task automatic idle_outs(input string tag);
    chk({tag, "_imem"}, {31'b0, imem_ren}, 0);
    chk({tag, "_dmem"}, {30'b0, dmem_ren, dmem_wen}, 0);
    chk({tag, "_pc_wb"}, {30'b0, pc_en, wb_en}, 0);
    chk({tag, "_halt_err"}, {30'b0, halt, stall_err}, 0);
    chk({tag, "_instr"}, instr, 0);
    chk({tag, "_dload"}, dload_q, 0);
  endtask
  task automatic fetch_hit(input word_t w, input string tag);
    ihit  = 1'b1;
    iload = w;
    iq.push_back(w);
    tick();
    ihit  = 1'b0;
    iload = '0;
    pop_instr({tag, "_instr"});
  endtask
  initial begin
    nrst = 1'b0; ihit = 1'b0; dhit = 1'b0; cu_dren = 1'b0; cu_dwen = 1'b0; cu_halt = 1'b0;
    iload = '0; dload = '0;
    repeat (3) tick();
    idle_outs("in_reset");
    nrst = 1'b1;
    idle_outs("release");
    tick();
    chk("first_fetch", {31'b0, imem_ren}, 1);
    fetch_hit(32'h00221820, "alu");
    chk("alu_decode_pc", {31'b0, pc_en}, 0);
    tick();
    chk("alu_commit", {30'b0, pc_en, wb_en}, 2'b11);
    chk("alu_no_dmem", {30'b0, dmem_ren, dmem_wen}, 0);
    tick();
    chk("alu_refetch", {30'b0, imem_ren, pc_en}, 2'b10);
    fetch_hit(32'h8c220004, "ld");
    cu_dren = 1'b1;
    tick();
    cu_dren = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ld_wait%0d", i), {29'b0, dmem_ren, dmem_wen, imem_ren}, 3'b100);
      tick();
    end
    chk("ld_hit_cycle", {29'b0, dmem_ren, dmem_wen, imem_ren}, 3'b100);
    dhit = 1'b1; dload = 32'hDEADBEEF; dq.push_back(32'hDEADBEEF);
    tick();
    dhit = 1'b0; dload = '0;
    chk("ld_commit", {29'b0, pc_en, wb_en, dmem_ren}, 3'b110);
    pop_dload("ld_dload");
    tick();
    chk("ld_refetch", {29'b0, imem_ren, pc_en, wb_en}, 3'b100);
    fetch_hit(32'hac220008, "st");
    cu_dren = 1'b1; cu_dwen = 1'b1;
    tick();
    cu_dren = 1'b0; cu_dwen = 1'b0;
    chk("st_write_only", {29'b0, dmem_ren, dmem_wen, imem_ren}, 3'b010);
    dhit = 1'b1; dload = 32'h12345678; dq.push_back(32'h12345678);
    tick();
    dhit = 1'b0; dload = '0;
    chk("st_commit", {30'b0, pc_en, dmem_wen}, 2'b10);
    pop_dload("st_dload");
    tick();
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) chk("wd_below", {31'b0, stall_err}, 0);
    end
    chk("wd_set", {30'b0, stall_err, imem_ren}, 2'b11);
    fetch_hit(32'hffffffff, "halt");
    chk("wd_sticky", {31'b0, stall_err}, 1);
    cu_halt = 1'b1; cu_dwen = 1'b1;
    tick();
    cu_halt = 1'b0; cu_dwen = 1'b0;
    chk("halted", {28'b0, halt, dmem_wen, dmem_ren, imem_ren}, 4'b1000);
    ihit = 1'b1; dhit = 1'b1; cu_dren = 1'b1;
    repeat (5) tick();
    ihit = 1'b0; dhit = 1'b0; cu_dren = 1'b0;
    chk("halt_absorb", {28'b0, halt, dmem_ren, imem_ren, pc_en}, 4'b1000);
    #2 nrst = 1'b0;
    #1 idle_outs("halt_reset");
    tick();
    nrst = 1'b1;
    tick();
    chk("post_halt_fetch", {31'b0, imem_ren}, 1);
    fetch_hit(32'h8c230000, "mid");
    cu_dren = 1'b1;
    tick();
    cu_dren = 1'b0;
    chk("mid_data", {31'b0, dmem_ren}, 1);
    #2 nrst = 1'b0;
    #1 chk("mid_drop", {29'b0, dmem_ren, pc_en, wb_en}, 0);
    tick();
    chk("mid_no_commit", {30'b0, pc_en, dmem_ren}, 0);
    nrst = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      fetch_hit(word_t'(k + 1), $sformatf("perf%0d", k));
      tick();
      tick();
    end
    chk("perf_instr", perf_instr_cnt, PERF_EXP);
    chk("perf_stall", perf_stall_cnt, PERF_EXP);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
